// File: rtl/beep_play_arbiter.sv
// Shares one buzzer player among an urgent alarm (req[0]) and two round-robin song sources.
// Times each play and inserts a silent gap so the player's note pointer restarts at note 0.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | nobody playing; arbitrate on any request
//   S_PLAY | winner plays; ends on completion, withdrawal or preemption
//   S_GAP  | forced silence; all requests ignored
module beep_play_arbiter #(
   parameter logic [29:0] PLAY_TIME = 30'd649_999_999,
   parameter logic [24:0] GAP_TIME  = 25'd24_999_999
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [2:0] req_i,
   output logic [2:0] gnt_o,
   output logic       player_en_o,
   output logic [1:0] song_sel_o,
   output logic [2:0] done_o,
   output logic       abort_o,
   output logic       busy_o
);

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

   state_t      state_q, state_d;
   logic [29:0] play_cnt_q, play_cnt_d;
   logic [24:0] gap_cnt_q, gap_cnt_d;
   logic        rr_last_q, rr_last_d;
   logic [2:0]  gnt_q, gnt_d;
   logic        player_en_q, player_en_d;
   logic [1:0]  song_sel_q, song_sel_d;
   logic [2:0]  done_q, done_d;
   logic        abort_q, abort_d;
   logic        busy_q, busy_d;
   logic [1:0]  win;
   logic        end_early;

   // rr_last_q = 1 means requester 2 was served last, so requester 1 takes a tie.
   always_comb begin
      win = 2'd2;
      if (req_i[0])
         win = 2'd0;
      else if (req_i[1] && req_i[2])
         win = rr_last_q ? 2'd1 : 2'd2;
      else if (req_i[1])
         win = 2'd1;
   end

   assign end_early = ((req_i & gnt_q) == 3'b000) || (req_i[0] && !gnt_q[0]);

   always_comb begin
      state_d     = state_q;
      play_cnt_d  = play_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      rr_last_d   = rr_last_q;
      gnt_d       = gnt_q;
      player_en_d = player_en_q;
      song_sel_d  = song_sel_q;
      done_d      = 3'b000;
      abort_d     = 1'b0;
      busy_d      = busy_q;
      case (state_q)
         S_IDLE: begin
            if (req_i != 3'b000) begin
               state_d     = S_PLAY;
               gnt_d       = 3'b001 << win;
               song_sel_d  = win;
               player_en_d = 1'b1;
               play_cnt_d  = '0;
               busy_d      = 1'b1;
               if (win != 2'd0)
                  rr_last_d = (win == 2'd2);
            end
         end
         S_PLAY: begin
            play_cnt_d = play_cnt_q + 30'd1;
            // Abort outranks a completion landing on the same edge.
            if (end_early || (play_cnt_q == PLAY_TIME)) begin
               state_d     = S_GAP;
               gap_cnt_d   = '0;
               gnt_d       = 3'b000;
               player_en_d = 1'b0;
               if (end_early)
                  abort_d = 1'b1;
               else
                  done_d = gnt_q;
            end
         end
         S_GAP: begin
            gap_cnt_d = gap_cnt_q + 25'd1;
            if (gap_cnt_q == GAP_TIME) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         play_cnt_q  <= '0;
         gap_cnt_q   <= '0;
         rr_last_q   <= 1'b1;
         gnt_q       <= 3'b000;
         player_en_q <= 1'b0;
         song_sel_q  <= 2'd0;
         done_q      <= 3'b000;
         abort_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         play_cnt_q  <= play_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         rr_last_q   <= rr_last_d;
         gnt_q       <= gnt_d;
         player_en_q <= player_en_d;
         song_sel_q  <= song_sel_d;
         done_q      <= done_d;
         abort_q     <= abort_d;
         busy_q      <= busy_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign player_en_o = player_en_q;
   assign song_sel_o  = song_sel_q;
   assign done_o      = done_q;
   assign abort_o     = abort_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_beep_play_arbiter.sv
// Bench for beep_play_arbiter: directed scenarios then random request toggling,
// every output compared each cycle against a play/gap reference model.
module tb_beep_play_arbiter;
   localparam int PT = 20;
   localparam int GT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] req;
   logic [2:0] gnt;
   logic       player_en;
   logic [1:0] song_sel;
   logic [2:0] done;
   logic       abort;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model
   bit         m_play, m_gap;
   int         m_owner, m_pcnt, m_gcnt, m_last, m_sel;
   logic [2:0] m_done;
   bit         m_abort;

   // independent timing watch
   int hi_run, lo_run;
   bit seen_play;

   beep_play_arbiter #(.PLAY_TIME(30'd20), .GAP_TIME(25'd4)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .player_en_o(player_en),
      .song_sel_o(song_sel), .done_o(done), .abort_o(abort), .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_play = 0; m_gap = 0; m_owner = 0; m_pcnt = 0; m_gcnt = 0;
      m_last = 2; m_sel = 0; m_done = 3'b000; m_abort = 0;
      hi_run = 0; lo_run = 0; seen_play = 0;
   endtask

   task automatic model_step(input logic [2:0] r);
      int w;
      m_done = 3'b000;
      m_abort = 0;
      if (m_play) begin
         if (!r[m_owner] || (r[0] && m_owner != 0)) begin
            m_abort = 1; m_play = 0; m_gap = 1; m_gcnt = 0;
         end else if (m_pcnt == PT) begin
            m_done[m_owner] = 1'b1; m_play = 0; m_gap = 1; m_gcnt = 0;
         end else
            m_pcnt++;
      end else if (m_gap) begin
         if (m_gcnt == GT) m_gap = 0;
         else m_gcnt++;
      end else if (r != 3'b000) begin
         if (r[0]) w = 0;
         else if (r[1] && r[2]) w = (m_last == 2) ? 1 : 2;
         else w = r[1] ? 1 : 2;
         m_owner = w; m_sel = w; m_play = 1; m_pcnt = 0;
         if (w != 0) m_last = w;
      end
   endtask

   task automatic check_outputs();
      logic [2:0] eg;
      eg = m_play ? 3'(1 << m_owner) : 3'b000;
      chk("gnt", 32'(gnt), 32'(eg));
      chk("player_en", 32'(player_en), 32'(m_play));
      chk("song_sel", 32'(song_sel), 32'(m_sel));
      chk("done", 32'(done), 32'(m_done));
      chk("abort", 32'(abort), 32'(m_abort));
      chk("busy", 32'(busy), 32'(m_play || m_gap));
   endtask

   task automatic timing_watch();
      if (player_en) begin
         if (hi_run == 0 && seen_play)
            chk("gap_min_len", 32'(lo_run >= GT + 2), 32'd1);
         hi_run++; lo_run = 0; seen_play = 1;
      end else begin
         if (done != 3'b000)
            chk("play_len", 32'(hi_run), 32'(PT + 1));
         hi_run = 0; lo_run++;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step(req);
      #1;
      check_outputs();
      timing_watch();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_play(input int who, input int cnt, input string tag);
      bit hit;
      hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         if (m_play && m_owner == who && m_pcnt == cnt) hit = 1;
         else cycle();
      end
      chk(tag, 32'(hit), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      req = 3'b000;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      rst = 1'b0;
      run(3);

      // single completed play, then repeat play
      req = 3'b010;
      run(30);
      chk("repeat_gnt", 32'(gnt), 32'b010);

      // round-robin
      req = 3'b110;
      run(85);

      // preemption of requester 2 by the alarm
      req = 3'b100;
      wait_play(2, 7, "wait_pre");
      req = 3'b101;
      cycle();
      chk("pre_abort", 32'(abort), 32'd1);
      run(GT + 2);
      chk("pre_gnt", 32'(gnt), 32'b001);
      chk("pre_sel", 32'(song_sel), 32'd0);
      run(5);

      // withdrawal
      req = 3'b010;
      wait_play(1, 3, "wait_wd");
      req = 3'b000;
      run(10);

      // abort and completion on the same edge; alarm raised inside gap
      req = 3'b100;
      wait_play(2, PT, "wait_sim");
      req = 3'b000;
      cycle();
      chk("sim_abort", 32'(abort), 32'd1);
      chk("sim_done", 32'(done), 32'd0);
      cycle();
      req = 3'b001;
      run(12);
      req = 3'b000;
      run(30);

      // asynchronous reset mid-play
      req = 3'b010;
      wait_play(1, 5, "wait_rst");
      #2 rst = 1'b1;
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_en", 32'(player_en), 32'd0);
      chk("rst_sel", 32'(song_sel), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_abort", 32'(abort), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      model_reset();
      #2 rst = 1'b0;
      run(40);

      // random request toggling
      req = 3'b000;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) req[$urandom_range(0, 2)] ^= 1'b1;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/beep_play_arbiter.md
# beep_play_arbiter

Shares the single on-board buzzer player among three song requesters: an urgent alarm and two ordinary song sources. It arbitrates requests, drives the player's `enable`, selects the song through `song_sel`, and times each play. It inserts a silent gap between plays so the player's note pointer returns to note 0. It sits between the key/alarm logic and the melody player in the top level.

## Interface
- `PLAY_TIME`, default 30'd649_999_999: play length minus 1, in clk cycles (13 s at 50 MHz).
- `GAP_TIME`, default 25'd24_999_999: silent gap minus 1, in clk cycles (500 ms).
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `req`  in  3  level requests.
  - bit0 = alarm: highest priority, preemptive.
  - bit1, bit2 = songs: round-robin between them.
  - A request is held until its `done` or `abort`.
- `gnt`  out  3  one-hot grant; all zeros when nobody is playing.
- `player_en`  out  1  enable to the melody player; high only in PLAY.
- `song_sel`  out  2  index of the granted requester (0/1/2); holds its last value outside PLAY.
- `done`  out  3  one-cycle pulse on the bit of a requester whose play ran the full PLAY_TIME.
- `abort`  out  1  one-cycle pulse when a play ends early.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, PLAY, GAP. Reset state is IDLE.
- All outputs are registered. Reset value of every output is 0.
- Internal counters and their reset values:
  - `play_cnt`: 30 bits, reset 0.
  - `gap_cnt`: 25 bits, reset 0.
  - `rr_last` (1 bit): 1 means requester 2 was served last; reset 1, so requester 1 wins the first tie.
- IDLE → PLAY, when any `req` bit is high. Winner selection:
  - `req[0]` wins if set.
  - Otherwise, if only one of bits 1/2 is set, that one wins.
  - If both are set, the one not served last (per `rr_last`) wins.
  - On the transition: set `gnt` one-hot to the winner, load `song_sel` with its index, set `player_en` = 1, clear `play_cnt`.
  - `rr_last` updates only when winner 1 or 2 is granted.
- PLAY: `play_cnt` increments every cycle. Checks in priority order:
  1. Reset.
  2. The granted requester drops its `req`: abort.
  3. `req[0]` is high and the winner is not 0: abort (preemption).
  4. `play_cnt` == PLAY_TIME: completion.
- Completion:
  - Pulse the winner's `done` bit.
  - Clear `gnt` and `player_en`.
  - Go to GAP with `gap_cnt` = 0.
- Abort:
  - Pulse `abort`; no `done`.
  - Clear `gnt` and `player_en`.
  - Go to GAP.
  - If abort and completion happen in the same cycle, abort wins.
- GAP:
  - `gap_cnt` increments every cycle.
  - At `gap_cnt` == GAP_TIME, go to IDLE.
  - Requests are ignored during GAP, including `req[0]`.
- A requester that still holds `req` after its `done` is granted again at the next IDLE arbitration (repeat play).
- Reset mid-operation:
  - All outputs and counters clear immediately (asynchronously); state returns to IDLE.
  - No `done` or `abort` pulse is issued.
- Counter comparisons use equality only. Counters never wrap in normal operation because they clear on every state entry.

## Timing
- `req` sampled high in IDLE at edge k: `gnt`, `player_en`, `song_sel` and `busy` are valid after edge k (1-cycle latency).
- `player_en` is high for exactly PLAY_TIME+1 cycles on a completed play.
- The `done` pulse coincides with the first GAP cycle and with `player_en` = 0.
- `player_en` is low for at least GAP_TIME+2 cycles between any two plays: GAP_TIME+1 cycles in GAP plus 1 cycle in IDLE.
- An abort takes effect on the edge after the triggering condition is sampled. `abort` and the `player_en` fall share that edge.
- `busy` falls on the edge that enters IDLE.

## Test plan
Benches use PLAY_TIME = 20 and GAP_TIME = 4.

1. **Reset values.** Assert `rst` asynchronously mid-cycle during PLAY.
   - Required: all outputs 0 immediately; IDLE afterwards.
   - No `done` or `abort` pulse.
2. **Single completed play.** `req` = 3'b010 held.
   - Required: `gnt` = 010 and `song_sel` = 1 one cycle later; `player_en` high for 21 cycles.
   - `done` = 010 for one cycle; `player_en` low for 6 cycles.
   - Then `gnt` = 010 again (repeat play).
3. **Round-robin.** `req` = 3'b110 held continuously.
   - Required: grants alternate 010, 100, 010.
   - Each play is 21 cycles with 6-cycle silences between plays.
4. **Preemption.** Raise `req[0]` at `play_cnt` = 7 while requester 2 plays.
   - Required: `abort` pulse the next cycle; no `done[2]`.
   - GAP of 5 cycles, then `gnt` = 001 and `song_sel` = 0.
5. **Requester withdrawal.** Drop `req[1]` at `play_cnt` = 3.
   - Required: `abort` pulse the next cycle, `player_en` = 0, `busy` stays high through GAP.
   - Return to IDLE with `gnt` = 000.
6. **Simultaneous events.** Drop `req[2]` in the same cycle that `play_cnt` reaches 20.
   - Required: `abort` pulses; `done` stays 000.
   - Also: `req[0]` raised during GAP is granted only after GAP ends.
